// File: rtl/acc25_scheduler.sv
// ----------------------------------------------------------------------------
// acc25_scheduler
//
// Round-robin scheduler in front of a multiply-by-25 accumulator. Two
// requesters compete for one job slot. The winner streams `len` 4-bit
// operands over a valid/ready bus. The block accumulates x*25 over the run
// and returns the total through a valid/ack handshake.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset; aborts any job in flight
//   req0/req1  : job request levels, held until the matching grant pulse
//   len0/len1  : operand count (0..15), sampled in the granting cycle
//   gnt0/gnt1  : one-cycle registered grant pulses
//   busy       : high whenever the scheduler is not idle
//   owner      : id of the current or last granted requester (operand mux)
//   x_valid/x  : operand stream from the granted requester
//   x_ready    : operand accept; high only while accumulating
//   res_valid  : result available, held until res_ack
//   res        : job sum of x*25
//   res_id     : requester that owns res
//   res_ack    : result consumed when res_valid & res_ack
// ----------------------------------------------------------------------------
module acc25_scheduler #(
    parameter int ACC_W = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [3:0]       len0,
    input  logic [3:0]       len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             owner,
    input  logic             x_valid,
    input  logic [3:0]       x,
    output logic             x_ready,
    output logic             res_valid,
    output logic [ACC_W-1:0] res,
    output logic             res_id,
    input  logic             res_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic             ptr;      // requester favoured when both request
    logic [3:0]       cnt;      // operands still to accept
    logic [ACC_W-1:0] acc;

    logic             win;
    logic [3:0]       win_len;
    logic [8:0]       prod;
    logic [ACC_W-1:0] acc_sum;

    // A lone request wins outright; on contention the pointer decides.
    assign win     = (req0 & req1) ? ptr : req1;
    assign win_len = win ? len1 : len0;

    // 15*25 = 375 fits in 9 bits.
    assign prod    = {5'b0, x} * 9'd25;
    assign acc_sum = acc + ACC_W'(prod);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            busy      <= 1'b0;
            owner     <= 1'b0;
            x_ready   <= 1'b0;
            res_valid <= 1'b0;
            res       <= '0;
            res_id    <= 1'b0;
        end else begin
            // Grants are single-cycle pulses.
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;

            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        owner <= win;
                        cnt   <= win_len;
                        acc   <= '0;
                        busy  <= 1'b1;
                        gnt0  <= ~win;
                        gnt1  <= win;
                        if (win_len != 4'd0) begin
                            state   <= ACCUM;
                            x_ready <= 1'b1;
                        end else begin
                            // Empty job: present a zero result right away.
                            state     <= DONE;
                            res_valid <= 1'b1;
                            res       <= '0;
                            res_id    <= win;
                        end
                    end
                end

                ACCUM: begin
                    // x_ready is held high for the whole state, so x_valid
                    // alone marks a transfer; x_valid low is a stall.
                    if (x_valid) begin
                        acc <= acc_sum;
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state     <= DONE;
                            x_ready   <= 1'b0;
                            res_valid <= 1'b1;
                            res       <= acc_sum;
                            res_id    <= owner;
                        end
                    end
                end

                DONE: begin
                    // res is left untouched after the ack.
                    if (res_ack) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        ptr       <= ~owner;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
